// File: rtl/add64_seq_pkg.sv
// add64_seq_pkg: shared types and constants for the 64-bit add/subtract
// sequencer that drives an external 32-bit pipelined adder.
//   WORD_W          - width of one adder word (32)
//   DWORD_W         - width of a full request operand / result (64)
//   ADD_LAT_DEFAULT - default adder latency in cycles
//   CNT_W           - wait-counter width, sized for ADD_LAT up to 7
//   state_e         - sequencer FSM states
package add64_seq_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DWORD_W         = 64;
    localparam int unsigned ADD_LAT_DEFAULT = 2;
    localparam int unsigned CNT_W           = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO_WAIT = 2'd1,
        HI_WAIT = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/add64_seq.sv
// add64_seq: single-outstanding sequencer that performs a 64-bit add or
// subtract on a sibling 32-bit pipelined adder. The low word is issued on
// accept, the adder's carry-out is fed back as carry-in for the high word,
// and the 64-bit result is returned with carry and signed-overflow flags.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_ready        - request handshake; in_a, in_b, in_sub operands
//   add_a/add_b/add_cin      - registered adder operands
//   add_sum/add_cout         - adder result (ADD_LAT cycles after sampling)
//   res_valid/res_ready      - result handshake
//   res_data/res_carry/res_ovf - 64-bit result, carry out of bit 63
//                              (1 = no borrow on subtract), signed overflow
module add64_seq
    import add64_seq_pkg::*;
#(
    parameter int unsigned ADD_LAT = ADD_LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DWORD_W-1:0]   in_a,
    input  logic [DWORD_W-1:0]   in_b,
    input  logic                 in_sub,
    output logic [WORD_W-1:0]    add_a,
    output logic [WORD_W-1:0]    add_b,
    output logic                 add_cin,
    input  logic [WORD_W-1:0]    add_sum,
    input  logic                 add_cout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DWORD_W-1:0]   res_data,
    output logic                 res_carry,
    output logic                 res_ovf
);

    // The counter holds "wait edges remaining minus one" and expires at zero,
    // giving the same ADD_LAT+1 edge wait while fitting ADD_LAT = 7 in 3 bits.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0]    a_hi_q, a_hi_d;
    logic [WORD_W-1:0]    b_hi_q, b_hi_d;
    logic [WORD_W-1:0]    add_a_q, add_a_d;
    logic [WORD_W-1:0]    add_b_q, add_b_d;
    logic                 add_cin_q, add_cin_d;
    logic [DWORD_W-1:0]   res_data_q, res_data_d;
    logic                 res_carry_q, res_carry_d;
    logic                 res_ovf_q, res_ovf_d;

    // Subtract is A + ~B + 1; the +1 enters as the low-word carry-in.
    logic [DWORD_W-1:0]   b_eff;
    assign b_eff = in_sub ? ~in_b : in_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_ovf_d   = res_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_hi_d    = in_a[DWORD_W-1:WORD_W];
                    b_hi_d    = b_eff[DWORD_W-1:WORD_W];
                    add_a_d   = in_a[WORD_W-1:0];
                    add_b_d   = b_eff[WORD_W-1:0];
                    add_cin_d = in_sub;
                    cnt_d     = CNT_LOAD;
                    state_d   = LO_WAIT;
                end
            end
            LO_WAIT: begin
                if (cnt_q == '0) begin
                    res_data_d[WORD_W-1:0] = add_sum;
                    add_a_d   = a_hi_q;
                    add_b_d   = b_hi_q;
                    add_cin_d = add_cout;
                    cnt_d     = CNT_LOAD;
                    state_d   = HI_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HI_WAIT: begin
                if (cnt_q == '0) begin
                    res_data_d[DWORD_W-1:WORD_W] = add_sum;
                    res_carry_d = add_cout;
                    res_ovf_d   = (a_hi_q[WORD_W-1] == b_hi_q[WORD_W-1]) &&
                                  (add_sum[WORD_W-1] != a_hi_q[WORD_W-1]);
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_ovf   = res_ovf_q;

endmodule
